// File: rtl/pread_sched.sv
`default_nettype none
// ============================================================================
// Module   : pread_sched
// Purpose  : Round-robin scheduler sharing one byte-in/word-out read assembler
//            among NUM_REQ byte-stream requesters. Grants one requester and
//            routes its byte lane to the assembler. Pulses the assembler start
//            strobe, waits for completion and hands the word back with a
//            one-cycle valid pulse to the winner.
// Ports    : clk, reset (async, active-high)
//            req[NUM_REQ]              per-requester level request
//            din_bus[NUM_REQ*IN_WIDTH] requester byte lanes
//            gnt[NUM_REQ]              one-hot grant, held START..DELIVER
//            rd_data[READ_WIDTH]       captured word, held until next capture
//            rd_valid[NUM_REQ]         one-hot one-cycle data-valid pulse
//            busy                      high whenever not IDLE
//            sh_enable/sh_din          assembler start strobe / muxed lane
//            sh_busy/sh_done/sh_dout   assembler status and word
// Options  : PREAD_SCHED_PRIO_EN - requester 0 gets fixed top priority; the
//            remaining requesters share round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module pread_sched #(
  parameter int NUM_REQ    = 4,
  parameter int READ_WIDTH = 32,
  parameter int IN_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*IN_WIDTH-1:0] din_bus,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [READ_WIDTH-1:0]       rd_data,
  output logic [NUM_REQ-1:0]          rd_valid,
  output logic                        busy,
  output logic                        sh_enable,
  output logic [IN_WIDTH-1:0]         sh_din,
  input  logic                        sh_busy,
  input  logic                        sh_done,
  input  logic [READ_WIDTH-1:0]       sh_dout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [NUM_REQ-1:0] cand;
  logic               launch;

  // Arbiter: scan from rr_ptr+1 upward with wrap; first pending requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = req;
`ifdef PREAD_SCHED_PRIO_EN
    // Requester 0 is handled by the fixed-priority override below, so the
    // rotating search only ever sees requesters 1..NUM_REQ-1.
    cand[0]  = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic logic [PTR_W-1:0] idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
`ifdef PREAD_SCHED_PRIO_EN
    if (req[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
`endif
  end

  // Never launch while the assembler is still working on something.
  assign launch = (state == IDLE) && pick_vld && !sh_busy;

  // Grant is one-hot, so an OR of gated lanes is a plain mux and yields zero
  // when nothing is granted.
  always_comb begin
    sh_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sh_din = sh_din | din_bus[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_enable = 1'b0;
    rd_valid  = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (launch) state_nxt = START;
      START: begin
        sh_enable = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (sh_done) state_nxt = DELIVER;
      DELIVER: begin
        // gnt is still held here, so it is exactly the winner's one-hot code.
        rd_valid  = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= '0;
      rd_data <= '0;
      win_idx <= '0;
      // Start the pointer at the last requester so requester 0 is first.
      rr_ptr  <= PTR_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            gnt     <= GNT_ONE << pick_idx;
            win_idx <= pick_idx;
          end
        end
        WAIT: begin
          if (sh_done) rd_data <= sh_dout;
        end
        DELIVER: begin
          gnt <= '0;
`ifdef PREAD_SCHED_PRIO_EN
          // Fixed-priority grants must not disturb the rotation of the rest.
          if (win_idx != '0) rr_ptr <= win_idx;
`else
          rr_ptr <= win_idx;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
